// File: rtl/pong_pkg.sv
// Shared pong definitions: game state codes, BCD score width, default period constants
// and the saturating two-digit BCD increment used by the score register.
package pong_pkg;

    typedef enum logic [2:0] {
        ATTRACT   = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        MISS      = 3'd4,
        GAME_OVER = 3'd5
    } pong_state_t;

    localparam int BCD_DIGIT_W      = 4;
    localparam int SCORE_W          = 2 * BCD_DIGIT_W;
    localparam int PERIOD_INIT_DEF  = 5000;
    localparam int PERIOD_MIN_DEF   = 1500;
    localparam int PERIOD_STEP_DEF  = 500;

    // Two-digit BCD +1 that holds at 99 instead of rolling over.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [BCD_DIGIT_W-1:0] lo;
        logic [BCD_DIGIT_W-1:0] hi;
        lo = v[BCD_DIGIT_W-1:0];
        hi = v[SCORE_W-1:BCD_DIGIT_W];
        if (hi == BCD_DIGIT_W'(9) && lo == BCD_DIGIT_W'(9)) begin
            return v;
        end
        if (lo == BCD_DIGIT_W'(9)) begin
            return {hi + BCD_DIGIT_W'(1), BCD_DIGIT_W'(0)};
        end
        return {hi, lo + BCD_DIGIT_W'(1)};
    endfunction

endpackage

// File: rtl/pong_game_sequencer_if.sv
// Bundle between the game sequencer (master) and the game engine / board side (slave).
interface pong_game_sequencer_if;
    import pong_pkg::*;

    logic               FRAME_START;
    logic               START_BUTTON;
    logic               PADDLE_HIT;
    logic               BALL_MISS;
    logic               SERVE;
    logic               BALL_RUN;
    logic [15:0]        BALL_PERIOD;
    logic [SCORE_W-1:0] SCORE;
    logic [1:0]         LIVES;
    logic [2:0]         STATE;

    modport master (
        input  FRAME_START, START_BUTTON, PADDLE_HIT, BALL_MISS,
        output SERVE, BALL_RUN, BALL_PERIOD, SCORE, LIVES, STATE
    );

    modport slave (
        output FRAME_START, START_BUTTON, PADDLE_HIT, BALL_MISS,
        input  SERVE, BALL_RUN, BALL_PERIOD, SCORE, LIVES, STATE
    );

endinterface

// File: rtl/pong_button_debounce.sv
// START button conditioner: 2-FF synchroniser, stability counter, one-cycle press on a
// debounced rising level.
module pong_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic VGA_CLOCK,
    input  logic RESET,
    input  logic START_BUTTON,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;

    // The counter only runs while the synchronised level differs from the accepted one,
    // so any return to the old level before the count completes discards the glitch.
    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            sync_reg   <= 2'b00;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
            press_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], START_BUTTON};
            press_reg <= 1'b0;
            if (sync_reg[1] != stable_reg) begin
                if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_reg <= sync_reg[1];
                    cnt_reg    <= '0;
                    press_reg  <= sync_reg[1];
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/pong_game_sequencer.sv
// Pong game-flow FSM: serve/play/pause/miss/game-over sequencing, BCD score and lives.
// Define PONG_SPEEDUP_EN to shorten the ball step period every HITS_PER_STEP hits.
module pong_game_sequencer
    import pong_pkg::*;
#(
    parameter int LIVES_INIT      = 3,
    parameter int SERVE_FRAMES    = 60,
    parameter int MISS_FRAMES     = 30,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PERIOD_INIT     = PERIOD_INIT_DEF,
    parameter int PERIOD_MIN      = PERIOD_MIN_DEF,
    parameter int PERIOD_STEP     = PERIOD_STEP_DEF,
    parameter int HITS_PER_STEP   = 4
) (
    input  logic                  VGA_CLOCK,
    input  logic                  RESET,
    pong_game_sequencer_if.master bus
);
    localparam int FRAME_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

    logic press;

    pong_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .VGA_CLOCK   (VGA_CLOCK),
        .RESET       (RESET),
        .START_BUTTON(bus.START_BUTTON),
        .press       (press)
    );

    pong_state_t        state_reg, state_next;
    logic               serve_reg, serve_next;
    logic               run_reg, run_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [1:0]         lives_reg, lives_next;
    logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic               new_game;

    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= ATTRACT;
            serve_reg     <= 1'b0;
            run_reg       <= 1'b0;
            score_reg     <= '0;
            lives_reg     <= 2'd0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            serve_reg     <= serve_next;
            run_reg       <= run_next;
            score_reg     <= score_next;
            lives_reg     <= lives_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        score_next     = score_reg;
        lives_next     = lives_reg;
        frame_cnt_next = frame_cnt_reg;
        new_game       = 1'b0;
        case (state_reg)
            ATTRACT: begin
                if (press) begin
                    state_next = SERVE;
                    new_game   = 1'b1;
                end
            end
            SERVE: begin
                if (bus.FRAME_START) begin
                    if (frame_cnt_reg == FRAME_W'(SERVE_FRAMES - 1)) begin
                        state_next     = PLAY;
                        frame_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + FRAME_W'(1);
                    end
                end
            end
            PLAY: begin
                // A miss overrides both a coincident hit and a coincident press.
                if (bus.BALL_MISS) begin
                    state_next     = MISS;
                    lives_next     = lives_reg - 2'd1;
                    frame_cnt_next = '0;
                end else begin
                    if (bus.PADDLE_HIT) begin
                        score_next = bcd_inc(score_reg);
                    end
                    if (press) begin
                        state_next = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (press) begin
                    state_next = PLAY;
                end
            end
            MISS: begin
                if (bus.FRAME_START) begin
                    if (frame_cnt_reg == FRAME_W'(MISS_FRAMES - 1)) begin
                        state_next     = (lives_reg == 2'd0) ? GAME_OVER : SERVE;
                        frame_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + FRAME_W'(1);
                    end
                end
            end
            GAME_OVER: begin
                if (press) begin
                    state_next = SERVE;
                    new_game   = 1'b1;
                end
            end
            default: state_next = ATTRACT;
        endcase
        if (new_game) begin
            score_next     = '0;
            lives_next     = 2'(LIVES_INIT);
            frame_cnt_next = '0;
        end
        serve_next = (state_next == SERVE) && (state_reg != SERVE);
        run_next   = (state_next == PLAY);
    end

`ifdef PONG_SPEEDUP_EN
    localparam int HIT_W = $clog2(HITS_PER_STEP + 1);

    logic             hit_event;
    logic [15:0]      period_reg, period_next;
    logic [HIT_W-1:0] hit_cnt_reg, hit_cnt_next;

    assign hit_event = (state_reg == PLAY) && bus.PADDLE_HIT && !bus.BALL_MISS;

    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            period_reg  <= 16'(PERIOD_INIT);
            hit_cnt_reg <= '0;
        end else begin
            period_reg  <= period_next;
            hit_cnt_reg <= hit_cnt_next;
        end
    end

    always_comb begin
        period_next  = period_reg;
        hit_cnt_next = hit_cnt_reg;
        if (new_game) begin
            period_next  = 16'(PERIOD_INIT);
            hit_cnt_next = '0;
        end else if (hit_event) begin
            if (hit_cnt_reg == HIT_W'(HITS_PER_STEP - 1)) begin
                hit_cnt_next = '0;
                // Floor rather than subtract below PERIOD_MIN so the period never wraps.
                if (period_reg >= 16'(PERIOD_MIN + PERIOD_STEP)) begin
                    period_next = period_reg - 16'(PERIOD_STEP);
                end else begin
                    period_next = 16'(PERIOD_MIN);
                end
            end else begin
                hit_cnt_next = hit_cnt_reg + HIT_W'(1);
            end
        end
    end

    assign bus.BALL_PERIOD = period_reg;
`else
    assign bus.BALL_PERIOD = 16'(PERIOD_INIT);
`endif

    assign bus.STATE    = state_reg;
    assign bus.SERVE    = serve_reg;
    assign bus.BALL_RUN = run_reg;
    assign bus.SCORE    = score_reg;
    assign bus.LIVES    = lives_reg;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Directed bench for pong_game_sequencer with a 4-cycle debounce; expectations hand-computed.
module tb_pong_game_sequencer;
    localparam int DEB = 4;

`ifdef PONG_SPEEDUP_EN
    localparam int EXP_P12  = 3500;
    localparam int EXP_P100 = 1500;
`else
    localparam int EXP_P12  = 5000;
    localparam int EXP_P100 = 5000;
`endif

    logic VGA_CLOCK = 1'b0;
    logic RESET     = 1'b1;
    int   n_checks  = 0;
    int   n_fail    = 0;

    pong_game_sequencer_if bus ();

    pong_game_sequencer #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .VGA_CLOCK(VGA_CLOCK),
        .RESET    (RESET),
        .bus      (bus)
    );

    always #5 VGA_CLOCK = ~VGA_CLOCK;

    task automatic check_value(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed != expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end else begin
            $display("ok   %s: %0h", tag, observed);
        end
    endtask

    task automatic tick();
        @(posedge VGA_CLOCK);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.FRAME_START = 1'b1;
            tick();
            bus.FRAME_START = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            bus.PADDLE_HIT = 1'b1;
            tick();
            bus.PADDLE_HIT = 1'b0;
            tick();
        end
    endtask

    // Holds the button until STATE moves; returns at the first cycle of the new state.
    task automatic press_button(input string tag);
        logic [2:0] old_state;
        bit         moved;
        old_state = bus.STATE;
        moved     = 1'b0;
        bus.START_BUTTON = 1'b1;
        for (int i = 0; i < 4 * DEB + 10 && !moved; i++) begin
            tick();
            if (bus.STATE != old_state) moved = 1'b1;
        end
        if (!moved) check_value({tag, "_press_timeout"}, 0, 1);
    endtask

    task automatic release_button();
        bus.START_BUTTON = 1'b0;
        repeat (DEB + 4) tick();
    endtask

    task automatic miss();
        bus.BALL_MISS = 1'b1;
        tick();
        bus.BALL_MISS = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check_value({tag, "_state"},  int'(bus.STATE),       0);
        check_value({tag, "_serve"},  int'(bus.SERVE),       0);
        check_value({tag, "_run"},    int'(bus.BALL_RUN),    0);
        check_value({tag, "_score"},  int'(bus.SCORE),       'h00);
        check_value({tag, "_lives"},  int'(bus.LIVES),       0);
        check_value({tag, "_period"}, int'(bus.BALL_PERIOD), 5000);
    endtask

    initial begin
        bus.FRAME_START  = 1'b0;
        bus.START_BUTTON = 1'b0;
        bus.PADDLE_HIT   = 1'b0;
        bus.BALL_MISS    = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        check_reset("reset");

        // Short glitch must not register
        bus.START_BUTTON = 1'b1;
        repeat (3) tick();
        bus.START_BUTTON = 1'b0;
        repeat (12) tick();
        check_value("glitch_state", int'(bus.STATE), 0);

        // New game
        press_button("start");
        check_value("start_state", int'(bus.STATE), 1);
        check_value("start_serve", int'(bus.SERVE), 1);
        check_value("start_score", int'(bus.SCORE), 'h00);
        check_value("start_lives", int'(bus.LIVES), 3);
        check_value("start_run",   int'(bus.BALL_RUN), 0);
        tick();
        check_value("serve_pulse_end", int'(bus.SERVE), 0);
        release_button();
        frames(59);
        check_value("serve_59", int'(bus.STATE), 1);
        frames(1);
        check_value("play_state", int'(bus.STATE), 2);
        check_value("play_run",   int'(bus.BALL_RUN), 1);

        hits(12);
        check_value("score_12",  int'(bus.SCORE), 'h12);
        check_value("period_12", int'(bus.BALL_PERIOD), EXP_P12);

        // Pause ignores events
        press_button("pause");
        check_value("pause_state", int'(bus.STATE), 3);
        check_value("pause_run",   int'(bus.BALL_RUN), 0);
        release_button();
        hits(1);
        miss();
        tick();
        check_value("pause_score", int'(bus.SCORE), 'h12);
        check_value("pause_lives", int'(bus.LIVES), 3);
        check_value("pause_hold",  int'(bus.STATE), 3);
        press_button("resume");
        check_value("resume_state", int'(bus.STATE), 2);
        release_button();

        // Hit and miss together: miss wins
        bus.PADDLE_HIT = 1'b1;
        bus.BALL_MISS  = 1'b1;
        tick();
        bus.PADDLE_HIT = 1'b0;
        bus.BALL_MISS  = 1'b0;
        check_value("hm_state", int'(bus.STATE), 4);
        check_value("hm_score", int'(bus.SCORE), 'h12);
        check_value("hm_lives", int'(bus.LIVES), 2);
        check_value("hm_run",   int'(bus.BALL_RUN), 0);
        frames(29);
        check_value("miss1_29", int'(bus.STATE), 4);
        frames(1);
        check_value("miss1_reserve", int'(bus.STATE), 1);
        frames(60);
        check_value("miss1_play", int'(bus.STATE), 2);

        miss();
        check_value("miss2_lives", int'(bus.LIVES), 1);
        frames(30);
        check_value("miss2_reserve", int'(bus.STATE), 1);
        frames(60);

        miss();
        check_value("miss3_lives", int'(bus.LIVES), 0);
        frames(30);
        check_value("gameover_state", int'(bus.STATE), 5);
        check_value("gameover_score", int'(bus.SCORE), 'h12);
        check_value("gameover_run",   int'(bus.BALL_RUN), 0);
        hits(1);
        check_value("gameover_hit_ignored", int'(bus.SCORE), 'h12);

        // Restart from game over reloads everything
        press_button("restart");
        check_value("restart_state",  int'(bus.STATE), 1);
        check_value("restart_serve",  int'(bus.SERVE), 1);
        check_value("restart_score",  int'(bus.SCORE), 'h00);
        check_value("restart_lives",  int'(bus.LIVES), 3);
        check_value("restart_period", int'(bus.BALL_PERIOD), 5000);
        release_button();
        frames(60);
        check_value("restart_play", int'(bus.STATE), 2);

        hits(9);
        check_value("score_09", int'(bus.SCORE), 'h09);
        hits(1);
        check_value("score_carry", int'(bus.SCORE), 'h10);
        hits(90);
        check_value("score_sat",  int'(bus.SCORE), 'h99);
        check_value("period_100", int'(bus.BALL_PERIOD), EXP_P100);

        // Reset mid-play
        RESET = 1'b1;
        tick();
        check_reset("midreset");
        RESET = 1'b0;
        tick();
        check_value("post_reset_serve", int'(bus.SERVE), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pong_game_sequencer.md
# pong_game_sequencer

Game-flow controller for the pong display pipeline. It sequences the ball/paddle datapath through attract, serve, play, pause, miss and game-over phases. It tells the game engine when to re-serve the ball, when the ball may move and at what step period, and it keeps score and lives. It runs entirely in the VGA_CLOCK domain, alongside the game engine, and consumes the engine's hit/miss event pulses.

## Interface
Parameters:
- LIVES_INIT, 3: lives loaded at each new game (1..3).
- SERVE_FRAMES, 60: frames the ball is held centred before motion starts.
- MISS_FRAMES, 30: frames of freeze after a miss.
- DEBOUNCE_CYCLES, 250000: cycles START_BUTTON must be stable to register a press.
- PERIOD_INIT, 5000: initial ball step period in VGA clocks.
- PERIOD_MIN, 1500: floor for ball step period.
- PERIOD_STEP, 500: period decrement per speed-up.
- HITS_PER_STEP, 4: paddle hits per speed-up.

Ports:
- VGA_CLOCK  in  1  pixel clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high.
- FRAME_START  in  1  one-cycle pulse at pixel (0,0) of each frame.
- START_BUTTON  in  1  raw asynchronous push-button, active-high.
- PADDLE_HIT  in  1  one-cycle pulse when the ball reflects off the paddle.
- BALL_MISS  in  1  one-cycle pulse when the ball passes the paddle.
- SERVE  out  1  one-cycle pulse; engine recentres ball and sets default direction.
- BALL_RUN  out  1  ball motion enable.
- BALL_PERIOD  out  16  ball step interval in VGA clocks.
- SCORE  out  8  two-digit BCD hit count.
- LIVES  out  2  remaining lives.
- STATE  out  3  current state code.

## Operation
- States and codes: ATTRACT=0, SERVE=1, PLAY=2, PAUSE=3, MISS=4, GAME_OVER=5.
- START press: START_BUTTON passes a 2-FF synchroniser, then must hold a new level for DEBOUNCE_CYCLES consecutive cycles. A debounced 0→1 transition yields a one-cycle `press`.
- ATTRACT → SERVE on press. New-game load: SCORE=0x00, LIVES=LIVES_INIT, BALL_PERIOD=PERIOD_INIT, hit counter=0.
- SERVE:
  - SERVE=1 on the first cycle in the state only; BALL_RUN=0.
  - Frame counter cleared on entry and incremented per FRAME_START.
  - → PLAY on the SERVE_FRAMES-th FRAME_START.
- PLAY: BALL_RUN=1.
  - PADDLE_HIT: SCORE BCD increment, saturating at 0x99; low digit wraps 9→0 with carry.
  - BALL_MISS → MISS, with LIVES decremented.
  - press → PAUSE.
- PAUSE: BALL_RUN=0; all events ignored; press → PLAY.
- MISS: BALL_RUN=0; frame counter cleared on entry. On the MISS_FRAMES-th FRAME_START: → GAME_OVER if LIVES==0, else → SERVE (score and period retained).
- GAME_OVER: BALL_RUN=0; SCORE and LIVES held for display; press → SERVE with new-game load.
- Simultaneous PADDLE_HIT and BALL_MISS in PLAY: miss wins, score unchanged.
- Simultaneous press and BALL_MISS in PLAY: miss wins, press dropped.
- PADDLE_HIT and BALL_MISS outside PLAY: ignored.
- LIVES never underflows; a decrement happens only in PLAY, where LIVES ≥ 1.

## Timing
- All outputs are registered.
- Reset values: STATE=0, SERVE=0, BALL_RUN=0, SCORE=0x00, LIVES=0, BALL_PERIOD=PERIOD_INIT; debounce and frame counters 0; synchroniser 0.
- Event at cycle N → STATE, BALL_RUN, SCORE, LIVES updated at N+1.
- SERVE high during cycle N+1 when the transition is decided at N.
- START_BUTTON edge → press pulse after 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES produce nothing.
- RESET mid-game: immediate return to ATTRACT with reset values; no SERVE pulse.
- A FRAME_START coincident with state entry is not counted.

## Configuration
- Macro: PONG_SPEEDUP_EN.
- Defined: each HITS_PER_STEP-th PADDLE_HIT in PLAY lowers BALL_PERIOD by PERIOD_STEP, floored at PERIOD_MIN (no wrap), and clears the hit counter. Reload to PERIOD_INIT happens only on a new game.
- Undefined: BALL_PERIOD is constant PERIOD_INIT; the hit counter is not built.

## Structure
- Shared package pong_pkg holds the state codes (ATTRACT..GAME_OVER), the BCD digit width and the default period constants. The game engine uses the same package.
- One sub-module, pong_button_debounce: synchroniser, stability counter and press-pulse output.
- Everything else (FSM, frame counter, BCD score, speed-up) lives in pong_game_sequencer.

## Test plan
- Reset then press (DEBOUNCE_CYCLES=4): STATE 0→1, one-cycle SERVE, SCORE=0x00, LIVES=3; after 60 FRAME_START pulses STATE=2 and BALL_RUN=1.
- 12 PADDLE_HIT in PLAY: SCORE=0x12. With PONG_SPEEDUP_EN, BALL_PERIOD=3500; without it, BALL_PERIOD=5000.
- Three BALL_MISS events, each followed by 30 frames: LIVES 2,1,0; re-serve after the first two; STATE=5 after the third; SCORE held.
- PADDLE_HIT and BALL_MISS in the same cycle: SCORE unchanged, STATE=4, LIVES decremented.
- 3-cycle button glitch: no state change. Press in PLAY → STATE=3 with BALL_RUN=0; events ignored; press again → STATE=2.
- 100 hits with speed-up: SCORE saturates at 0x99; BALL_PERIOD floors at 1500. RESET asserted mid-PLAY → all outputs return to reset values next cycle.
